control_unit: RTL

Fetch/decode/execute sequencer for the 8-bit CPU. It owns the program counter and sits directly downstream of `instruction_register`: it consumes the latched instruction byte and drives every control strobe in the datapath. Those strobes are the IR load, the accumulator load and ALU opcode, and the memory address and write enable. One instruction runs at a time through a Moore state machine, with no pipelining.

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/instruction_decoder.sv | 62 ++++++
 rtl/control_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode, ALU and FSM state definitions for the 8-bit CPU control path.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_AND = 4'h8;
    localparam logic [3:0] OP_OR  = 4'h9;
    localparam logic [3:0] OP_XOR = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_PASS_B = 4'd5;

    typedef enum logic [2:0] {
        ST_FETCH0,
        ST_FETCH1,
        ST_DECODE,
        ST_OPER0,
        ST_OPER1,
        ST_EXEC,
        ST_MEMWB,
        ST_HALT
    } state_e;

    typedef struct packed {
        logic       two_byte;
        logic       is_mem_read;
        logic       is_store;
        logic       is_jump;
        logic       is_cond;
        logic       is_halt;
        logic       is_illegal;
        logic [3:0] alu_op;
    } dec_t;

endpackage

// File: rtl/instruction_decoder.sv
// Pure combinational opcode classifier feeding the control_unit sequencer.
import cpu_pkg::*;

module instruction_decoder (
    input  logic [3:0] opcode_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o        = '0;
        dec_o.alu_op = ALU_PASS_B;
        case (opcode_i)
            OP_NOP: ;
            OP_LDA: begin
                dec_o.two_byte    = 1'b1;
                dec_o.is_mem_read = 1'b1;
            end
            OP_ADD: begin
                dec_o.two_byte    = 1'b1;
                dec_o.is_mem_read = 1'b1;
                dec_o.alu_op      = ALU_ADD;
            end
            OP_SUB: begin
                dec_o.two_byte    = 1'b1;
                dec_o.is_mem_read = 1'b1;
                dec_o.alu_op      = ALU_SUB;
            end
            OP_AND: begin
                dec_o.two_byte    = 1'b1;
                dec_o.is_mem_read = 1'b1;
                dec_o.alu_op      = ALU_AND;
            end
            OP_OR: begin
                dec_o.two_byte    = 1'b1;
                dec_o.is_mem_read = 1'b1;
                dec_o.alu_op      = ALU_OR;
            end
            OP_XOR: begin
                dec_o.two_byte    = 1'b1;
                dec_o.is_mem_read = 1'b1;
                dec_o.alu_op      = ALU_XOR;
            end
            OP_STA: begin
                dec_o.two_byte = 1'b1;
                dec_o.is_store = 1'b1;
            end
            OP_LDI: dec_o.two_byte = 1'b1;
            OP_JMP: begin
                dec_o.two_byte = 1'b1;
                dec_o.is_jump  = 1'b1;
            end
            OP_JZ: begin
                dec_o.two_byte = 1'b1;
                dec_o.is_jump  = 1'b1;
                dec_o.is_cond  = 1'b1;
            end
            OP_HLT:  dec_o.is_halt    = 1'b1;
            default: dec_o.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer: owns pc and operand register, drives datapath strobes.
//   state  | meaning
//   FETCH0 | read request at pc
//   FETCH1 | IR captures opcode byte, pc++
//   DECODE | classify opcode, latch it
//   OPER0  | read request at pc for operand, pc++
//   OPER1  | operand register captures read data
//   EXEC   | store / jump / LDI / memory read request
//   MEMWB  | accumulator takes ALU result with memory
//   HALT   | frozen until reset
import cpu_pkg::*;

module control_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instr,
    input  logic [7:0] mem_rdata,
    input  logic       zero_flag,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic       ir_load,
    output logic       acc_load,
    output logic [3:0] alu_op,
    output logic       alu_b_sel,
    output logic [7:0] operand,
    output logic [7:0] pc,
    output logic       halted,
    output logic       illegal
);

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] operand_q, operand_d;
    logic [3:0] opcode_q, opcode_d;
    logic [3:0] opcode_cur;
    dec_t       dec;
    logic       unused_instr_lo;

    assign unused_instr_lo = ^instr[3:0];

    // IR output is only fresh from DECODE on; later states use the latched copy.
    assign opcode_cur = (state_q == ST_DECODE) ? instr[7:4] : opcode_q;

    instruction_decoder u_dec (
        .opcode_i (opcode_cur),
        .dec_o    (dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH0;
            pc_q      <= RESET_PC;
            operand_q <= 8'h00;
            opcode_q  <= OP_NOP;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            operand_q <= operand_d;
            opcode_q  <= opcode_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        operand_d = operand_q;
        opcode_d  = opcode_q;
        mem_addr  = pc_q;
        mem_we    = 1'b0;
        ir_load   = 1'b0;
        acc_load  = 1'b0;
        alu_op    = ALU_ADD;
        alu_b_sel = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            ST_FETCH0: state_d = ST_FETCH1;
            ST_FETCH1: begin
                ir_load = 1'b1;
                pc_d    = pc_q + 8'd1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                opcode_d = instr[7:4];
                if (dec.is_illegal) begin
                    illegal = 1'b1;
                    state_d = ST_FETCH0;
                end else if (dec.is_halt) begin
                    state_d = ST_HALT;
                end else if (dec.two_byte) begin
                    state_d = ST_OPER0;
                end else begin
                    state_d = ST_FETCH0;
                end
            end
            ST_OPER0: begin
                pc_d    = pc_q + 8'd1;
                state_d = ST_OPER1;
            end
            ST_OPER1: begin
                operand_d = mem_rdata;
                state_d   = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec.is_store) begin
                    mem_addr = operand_q;
                    mem_we   = 1'b1;
                    state_d  = ST_FETCH0;
                end else if (dec.is_mem_read) begin
                    mem_addr = operand_q;
                    state_d  = ST_MEMWB;
                end else if (dec.is_jump) begin
                    if (!dec.is_cond || zero_flag) begin
                        pc_d = operand_q;
                    end
                    state_d = ST_FETCH0;
                end else begin
                    acc_load  = 1'b1;
                    alu_op    = ALU_PASS_B;
                    alu_b_sel = 1'b1;
                    state_d   = ST_FETCH0;
                end
            end
            ST_MEMWB: begin
                acc_load = 1'b1;
                alu_op   = dec.alu_op;
                state_d  = ST_FETCH0;
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_FETCH0;
        endcase
    end

    assign operand = operand_q;
    assign pc      = pc_q;

endmodule
